// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for a 4-digit, common-anode style 7-segment
//   display. Each digit is preceded by BLANK_CYCLES clocks with everything
//   off (ghosting guard) and is then driven for DWELL_CYCLES clocks. The
//   displayed value is latched into a shadow register once per frame, so a
//   frame never shows a mix of old and new data.
//
//   Optional feature: define SEG_LZ_SUPPRESS_EN to blank leading zeros on
//   digits 3..1. Digit0 is always shown, and decimal points are still driven.
//
// Parameters
//   DWELL_CYCLES  clocks each digit is driven (>= 1)
//   BLANK_CYCLES  clocks of dead time before each digit (0 = no blank phase)
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   digits[15:0] in   four hex nibbles, digit0 = [3:0]
//   dp[3:0]      in   decimal point per digit, 1 = lit
//   load         in   capture digits/dp into the pending register
//   seg[6:0]     out  active-low segments, bit0 = a ... bit6 = g
//   dp_n         out  active-low decimal point
//   sel[3:0]     out  active-high one-hot digit enable
//   frame_start  out  pulse on the first driven cycle of digit0
//   dbg_state    out  {fsm state (1 = DRIVE), idx[1:0]}
//
// Handshake: load is a level-qualified strobe with no ready; every clock on
// which load is high overwrites the pending value, and the last one captured
// before a frame boundary is what the next frame shows.
module seg_scan_driver #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  sel,
    output logic        frame_start,
    output logic [2:0]  dbg_state
);

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic          BLANK_EN   = (BLANK_CYCLES > 0);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t        state, state_d;
    logic [1:0]    idx, idx_d;
    logic [TW-1:0] timer, timer_d;
    logic [15:0]   pend_digits, shadow_digits, src_digits;
    logic [3:0]    pend_dp, shadow_dp, src_dp;
    logic          in_drive, frame_entry, lz_blank;
    logic [3:0]    nibble;
    logic [6:0]    seg_d;
    logic          dp_n_d, frame_start_d;
    logic [3:0]    sel_d;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // With no blank phase the BLANK state (only reachable through reset)
    // behaves exactly like DRIVE, so sel appears on the first edge after reset.
    assign in_drive    = (state == ST_DRIVE) || !BLANK_EN;
    assign frame_entry = in_drive && (idx == 2'd0) && (timer == '0);

    // Data shown this cycle. On the frame entry cycle a concurrent load is
    // forwarded past the pending register straight into display and shadow.
    assign src_digits = frame_entry ? (load ? digits : pend_digits) : shadow_digits;
    assign src_dp     = frame_entry ? (load ? dp     : pend_dp)     : shadow_dp;
    assign nibble     = src_digits[idx*4 +: 4];

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= ST_BLANK;
            idx   <= 2'd0;
            timer <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            timer <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        idx_d   = idx;
        timer_d = timer + TW'(1);
        if (in_drive) begin
            state_d = ST_DRIVE;
            if (timer == DWELL_LAST) begin
                timer_d = '0;
                idx_d   = idx + 2'd1;
                state_d = BLANK_EN ? ST_BLANK : ST_DRIVE;
            end
        end else if (timer == BLANK_LAST) begin
            timer_d = '0;
            state_d = ST_DRIVE;
        end
    end

    // Output decode; registered below so outputs lag the state by one clock.
    always_comb begin
        lz_blank = 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
        case (idx)
            2'd1:    lz_blank = (src_digits[15:4]  == 12'h000);
            2'd2:    lz_blank = (src_digits[15:8]  == 8'h00);
            2'd3:    lz_blank = (src_digits[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
        sel_d         = 4'b0000;
        seg_d         = 7'h7F;
        dp_n_d        = 1'b1;
        frame_start_d = frame_entry;
        if (in_drive) begin
            sel_d  = 4'(4'b0001 << idx);
            seg_d  = lz_blank ? 7'h7F : glyph(nibble);
            dp_n_d = ~src_dp[idx];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sel           <= 4'b0000;
            seg           <= 7'h7F;
            dp_n          <= 1'b1;
            frame_start   <= 1'b0;
            pend_digits   <= 16'h0000;
            pend_dp       <= 4'h0;
            shadow_digits <= 16'h0000;
            shadow_dp     <= 4'h0;
        end else begin
            sel         <= sel_d;
            seg         <= seg_d;
            dp_n        <= dp_n_d;
            frame_start <= frame_start_d;
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp;
            end
            if (frame_entry) begin
                shadow_digits <= src_digits;
                shadow_dp     <= src_dp;
            end
        end
    end

    assign dbg_state = {state, idx};

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DWELL  = 4;
    localparam int BLANK  = 2;
    localparam int PHASE  = DWELL + BLANK;
    localparam int FRAME  = 4 * PHASE;
    localparam int NVEC   = 122;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        load;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  sel;
    logic        frame_start;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ld;
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  sel;
        logic [6:0]  seg;
        logic        dpn;
        logic        fs;
    } vec_t;

    vec_t vecs [NVEC];

    seg_scan_driver #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .digits      (digits),
        .dp          (dp),
        .load        (load),
        .seg         (seg),
        .dp_n        (dp_n),
        .sel         (sel),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: ref_glyph = 7'b1000000;
            4'h1: ref_glyph = 7'b1111001;
            4'h2: ref_glyph = 7'b0100100;
            4'h3: ref_glyph = 7'b0110000;
            4'h4: ref_glyph = 7'b0011001;
            4'h5: ref_glyph = 7'b0010010;
            4'h6: ref_glyph = 7'b0000010;
            4'h7: ref_glyph = 7'b1111000;
            4'h8: ref_glyph = 7'b0000000;
            4'h9: ref_glyph = 7'b0010000;
            4'hA: ref_glyph = 7'b0001000;
            4'hB: ref_glyph = 7'b0000011;
            4'hC: ref_glyph = 7'b1000110;
            4'hD: ref_glyph = 7'b0100001;
            4'hE: ref_glyph = 7'b0000110;
            default: ref_glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
        logic [15:0] hi;
        hi = v >> (4 * k);
`ifdef SEG_LZ_SUPPRESS_EN
        if (k > 0 && hi == 16'h0000) return 7'h7F;
`endif
        return ref_glyph(hi[3:0]);
    endfunction

    // Expected outputs after edge c (c = 0 is the first edge with reset high):
    // two blank edges, then per digit DWELL driven + BLANK dead clocks.
    function automatic vec_t mk_vec(input int c, input logic ld, input logic [15:0] d,
                                    input logic [3:0] p, input logic [15:0] show_d,
                                    input logic [3:0] show_p);
        vec_t v;
        int pos, dig, ph;
        v.ld = ld; v.d = d; v.p = p;
        v.sel = 4'b0000; v.seg = 7'h7F; v.dpn = 1'b1; v.fs = 1'b0;
        if (c >= BLANK) begin
            pos = (c - BLANK) % FRAME;
            dig = pos / PHASE;
            ph  = pos % PHASE;
            if (ph < DWELL) begin
                v.sel = 4'(1 << dig);
                v.seg = exp_seg(show_d, dig);
                v.dpn = ~show_p[dig];
                v.fs  = (pos == 0);
            end
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [3:0] e_sel, input logic [6:0] e_seg,
                               input logic e_dpn, input logic e_fs);
        chk({tag, ".sel"},         16'(sel),         16'(e_sel));
        chk({tag, ".seg"},         16'(seg),         16'(e_seg));
        chk({tag, ".dp_n"},        16'(dp_n),        16'(e_dpn));
        chk({tag, ".frame_start"}, 16'(frame_start), 16'(e_fs));
    endtask

    initial begin
        logic [15:0] show_d, ld_d;
        logic [3:0]  show_p, ld_p;
        logic        ld;
        int          n;

        // vector table: loads and the value each frame must display
        for (int c = 0; c < NVEC; c++) begin
            ld = 1'b0; ld_d = 16'(c * 16'h9E37); ld_p = 4'(c);
            case (c)
                0:  begin ld = 1'b1; ld_d = 16'h1234; ld_p = 4'b0000; end
                28: begin ld = 1'b1; ld_d = 16'h5555; ld_p = 4'b1111; end
                33: begin ld = 1'b1; ld_d = 16'hABCD; ld_p = 4'b0000; end
                74: begin ld = 1'b1; ld_d = 16'h00EF; ld_p = 4'b0101; end
                80: begin ld = 1'b1; ld_d = 16'h0050; ld_p = 4'b0000; end
                default: ;
            endcase
            if (c < 50)      begin show_d = 16'h1234; show_p = 4'b0000; end
            else if (c < 74) begin show_d = 16'hABCD; show_p = 4'b0000; end
            else if (c < 98) begin show_d = 16'h00EF; show_p = 4'b0101; end
            else             begin show_d = 16'h0050; show_p = 4'b0000; end
            vecs[c] = mk_vec(c, ld, ld_d, ld_p, show_d, show_p);
        end

        // reset
        reset = 1'b0; load = 1'b0; digits = 16'hFFFF; dp = 4'hF;
        repeat (3) tick();
        chk_outputs("reset", 4'b0000, 7'h7F, 1'b1, 1'b0);
        reset = 1'b1;

        // table-driven run
        for (int i = 0; i < NVEC; i++) begin
            load = vecs[i].ld; digits = vecs[i].d; dp = vecs[i].p;
            tick();
            chk_outputs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].seg, vecs[i].dpn, vecs[i].fs);
        end
        load = 1'b0;

        // reset pulse in the middle of digit2's drive
        n = 0;
        while (sel !== 4'b0100 && n < 100) begin
            tick();
            n++;
        end
        chk("wait_digit2", 16'(n < 100), 16'd1);
        chk("digit2_seg", 16'(seg), 16'(exp_seg(16'h0050, 2)));
        tick();
        reset = 1'b0;
        tick();
        chk_outputs("mid_reset", 4'b0000, 7'h7F, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_outputs("rel_e0", 4'b0000, 7'h7F, 1'b1, 1'b0);
        tick();
        chk_outputs("rel_e1", 4'b0000, 7'h7F, 1'b1, 1'b0);
        tick();
        chk_outputs("rel_e2", 4'b0001, 7'b1000000, 1'b1, 1'b1);
        for (int k = 1; k < DWELL; k++) begin
            tick();
            chk_outputs($sformatf("rel_dwell%0d", k), 4'b0001, 7'b1000000, 1'b1, 1'b0);
        end
        tick();
        chk_outputs("rel_blank", 4'b0000, 7'h7F, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000: clocks each digit is driven (1 ms at 50 MHz); legal range 1 or more.
REQ-002 Parameter BLANK_CYCLES, default 500: clocks of dead time before each digit; 0 removes the blank phase.
REQ-003 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 digits  input  16  four hex nibbles; digit0 = [3:0], digit3 = [15:12].
REQ-006 dp  input  4  decimal point per digit, 1 = lit.
REQ-007 load  input  1  when high for one or more clocks, captures digits/dp into the pending register.
REQ-008 seg  output  7  active-low segments, bit0 = a ... bit6 = g.
REQ-009 dp_n  output  1  active-low decimal point.
REQ-010 sel  output  4  active-high one-hot digit enable; 4'b0000 = no digit.
REQ-011 frame_start  output  1  single-cycle pulse on the first DRIVE cycle of digit0.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 FSM states: BLANK and DRIVE; the index idx runs 0..3.
REQ-014 BLANK: sel = 0, seg = 7'h7F, dp_n = 1; lasts exactly BLANK_CYCLES clocks, then enters DRIVE with the same idx.
REQ-015 DRIVE: sel = one-hot(idx), seg = glyph(shadow nibble idx), dp_n = ~shadow_dp[idx]; lasts exactly DWELL_CYCLES clocks, then idx = (idx+1) mod 4 and the FSM enters BLANK.
REQ-016 With BLANK_CYCLES = 0, DRIVE SHALL transition directly to DRIVE of the next idx, with no all-off cycle.
REQ-017 Frame period SHALL be exactly 4*(DWELL_CYCLES+BLANK_CYCLES) clocks.
REQ-018 Glyphs (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 Shadow register (digits+dp) SHALL update only on the clock that enters DRIVE for idx 0; displayed data SHALL never change within a frame.
REQ-020 A load in the same clock as the shadow update SHALL be forwarded: the shadow takes the live digits/dp, not the older pending value.
REQ-021 Multiple loads within one frame: only the last captured value SHALL be displayed in the next frame.
REQ-022 The dwell/blank timer SHALL be wide enough for the maximum parameter value; no wrap SHALL occur before the terminal count.

Reset
REQ-023 While reset = 0 at a clock edge: state = BLANK, idx = 0, timer = 0, sel = 4'b0000, seg = 7'h7F, dp_n = 1, frame_start = 0, pending = 0, shadow = 0.
REQ-024 Reset mid-DRIVE SHALL blank all outputs on the next clock, with no partial dwell resumed.
REQ-025 After reset releases, sel = 4'b0001 SHALL first appear BLANK_CYCLES clocks after the first edge sampled with reset = 1, together with frame_start = 1.

Configuration
REQ-026 Macro SEG_LZ_SUPPRESS_EN defined: digits 3..1 whose nibble and all higher nibbles are zero SHALL output seg = 7'h7F (dp still honoured); sel timing is unchanged; digit0 is always shown.
REQ-027 Macro SEG_LZ_SUPPRESS_EN undefined: every digit SHALL be decoded per REQ-018, including leading zeros.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-028 Reset, load 16'h1234, dp=0 -> frame after next boundary: digit0 seg=0011001, digit1 0110000, digit2 0100100, digit3 1111001; dp_n=1 throughout.
REQ-029 Free run -> sel sequence 0001, 0010, 0100, 1000, each for 4 clocks and each preceded by 2 clocks of 0000; frame_start every 24 clocks.
REQ-030 Load 16'hABCD in the middle of digit1's DRIVE of a 16'h1234 frame -> digits 2 and 3 still show 2 and 1; next frame shows d, C, b, A.
REQ-031 Load 16'h00EF asserted exactly on the digit0 DRIVE entry clock -> that same frame shows F at digit0.
REQ-032 reset=0 for 1 clock during digit2 DRIVE -> next clock sel=0000 and seg=7F; digit0 is re-driven 2 clocks after release, shadow=0 so glyph 1000000.
REQ-033 Load 16'h0050 -> with SEG_LZ_SUPPRESS_EN: digits 3 and 2 seg=7F, digit1=0010010, digit0=1000000; without the macro, digits 3 and 2 show 1000000.
